// File: rtl/lcd_timing_pkg.sv
// Shared timing constants for the 480x272 RGB LCD raster.
// Counter width bounds both axis counters and the pixel coordinates.
package lcd_timing_pkg;

   localparam int CNT_W = 10;

   localparam int DEF_H_ACTIVE = 480;
   localparam int DEF_H_FP     = 2;
   localparam int DEF_H_SYNC   = 41;
   localparam int DEF_H_BP     = 2;

   localparam int DEF_V_ACTIVE = 272;
   localparam int DEF_V_FP     = 2;
   localparam int DEF_V_SYNC   = 10;
   localparam int DEF_V_BP     = 2;

   localparam int DEF_H_TOTAL =
      DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_TOTAL =
      DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

endpackage

// File: rtl/lcd_axis_cnt.sv
// Generic wrap counter for one raster axis, with active/sync decode.
// Region bounds are half-open: [0,act_end) and [sync_beg,sync_end).
module lcd_axis_cnt
   import lcd_timing_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] last,
   input  logic [CNT_W-1:0] act_end,
   input  logic [CNT_W-1:0] sync_beg,
   input  logic [CNT_W-1:0] sync_end,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap,
   output logic             active,
   output logic             sync
);

   logic at_last;

   assign at_last = (cnt == last);
   assign wrap    = en && at_last;
   assign active  = (cnt < act_end);
   assign sync    = (cnt >= sync_beg) && (cnt < sync_end);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= at_last ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/lcd_timing_gen.sv
// Raster timing generator: HSYNC/VSYNC/DE and pixel coordinates.
// Raster is held at (0,0) with idle outputs until PLL lock is seen.
module lcd_timing_gen
   import lcd_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pll_lock,
   output logic             lcd_hs,
   output logic             lcd_vs,
   output logic             lcd_de,
   output logic [CNT_W-1:0] pix_x,
   output logic [CNT_W-1:0] pix_y,
   output logic             frame_start,
   output logic             line_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] H_SBEG  = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] H_SEND  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] V_SBEG  = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] V_SEND  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic             lock_m;
   logic             lock_s;
   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             h_wrap;
   logic             v_wrap;
   logic             h_act;
   logic             v_act;
   logic             h_sync;
   logic             v_sync;
   logic             de_d;
   logic             h_zero;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= pll_lock;
         lock_s <= lock_m;
      end
   end

   lcd_axis_cnt u_h_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (!lock_s),
      .en       (lock_s),
      .last     (H_LAST),
      .act_end  (H_ACT),
      .sync_beg (H_SBEG),
      .sync_end (H_SEND),
      .cnt      (h_cnt),
      .wrap     (h_wrap),
      .active   (h_act),
      .sync     (h_sync)
   );

   // V advances only on the H wrap, so v_cnt and VSYNC move at h_cnt=0.
   lcd_axis_cnt u_v_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (!lock_s),
      .en       (h_wrap),
      .last     (V_LAST),
      .act_end  (V_ACT),
      .sync_beg (V_SBEG),
      .sync_end (V_SEND),
      .cnt      (v_cnt),
      .wrap     (v_wrap),
      .active   (v_act),
      .sync     (v_sync)
   );

   assign de_d   = h_act && v_act;
   assign h_zero = (h_cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lcd_hs      <= ~HS_POL;
         lcd_vs      <= ~VS_POL;
         lcd_de      <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         frame_start <= 1'b0;
         line_start  <= 1'b0;
      end else if (!lock_s) begin
         lcd_hs      <= ~HS_POL;
         lcd_vs      <= ~VS_POL;
         lcd_de      <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         frame_start <= 1'b0;
         line_start  <= 1'b0;
      end else begin
         lcd_hs      <= h_sync ? HS_POL : ~HS_POL;
         lcd_vs      <= v_sync ? VS_POL : ~VS_POL;
         lcd_de      <= de_d;
         frame_start <= de_d && h_zero && (v_cnt == '0);
         line_start  <= de_d && h_zero;
         // Coordinates hold their last active value through blanking.
         if (de_d) begin
            pix_x <= h_cnt;
            pix_y <= v_cnt;
         end
      end
   end

   logic unused_ok;
   assign unused_ok = v_wrap;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Self-checking bench: default-geometry DUT plus a small, inverted-polarity
// DUT, both compared every clock against an arithmetic raster model.
module tb_lcd_timing_gen;

   typedef struct {
      logic       hs;
      logic       vs;
      logic       de;
      logic [9:0] px;
      logic [9:0] py;
      logic       fs;
      logic       ls;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_lock = 1'b0;

   logic       d_hs, d_vs, d_de, d_fs, d_ls;
   logic [9:0] d_px, d_py;
   logic       s_hs, s_vs, s_de, s_fs, s_ls;
   logic [9:0] s_px, s_py;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   bit   s1, s2;
   int   t_d, t_s;
   exp_t e_d, e_s;

   always #5 clk = ~clk;

   lcd_timing_gen dut_d (
      .clk(clk), .rst(rst), .pll_lock(pll_lock),
      .lcd_hs(d_hs), .lcd_vs(d_vs), .lcd_de(d_de),
      .pix_x(d_px), .pix_y(d_py),
      .frame_start(d_fs), .line_start(d_ls)
   );

   lcd_timing_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(5), .H_BP(3),
      .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2),
      .HS_POL(1'b1), .VS_POL(1'b1)
   ) dut_s (
      .clk(clk), .rst(rst), .pll_lock(pll_lock),
      .lcd_hs(s_hs), .lcd_vs(s_vs), .lcd_de(s_de),
      .pix_x(s_px), .pix_y(s_py),
      .frame_start(s_fs), .line_start(s_ls)
   );

   function automatic exp_t idle(bit hp, bit vp);
      exp_t e;
      e.hs = ~hp; e.vs = ~vp; e.de = 1'b0;
      e.px = '0;  e.py = '0;  e.fs = 1'b0; e.ls = 1'b0;
      return e;
   endfunction

   // Output expected for the t-th locked cycle of a raster.
   function automatic exp_t dec(int t, int ha, int hf, int hw, int hb,
                                int va, int vf, int vw, int vb,
                                bit hp, bit vp, exp_t prev);
      exp_t e;
      int ht, vt, x, y;
      ht = ha + hf + hw + hb;
      vt = va + vf + vw + vb;
      x = t % ht;
      y = (t / ht) % vt;
      e.de = (x < ha) && (y < va);
      e.hs = (x >= ha + hf && x < ha + hf + hw) ? hp : ~hp;
      e.vs = (y >= va + vf && y < va + vf + vw) ? vp : ~vp;
      e.px = e.de ? 10'(x) : prev.px;
      e.py = e.de ? 10'(y) : prev.py;
      e.fs = e.de && x == 0 && y == 0;
      e.ls = e.de && x == 0;
      return e;
   endfunction

   task automatic chk(string tag, logic [9:0] obs, logic [9:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%0d expected=%0d",
                tag, cyc, obs, exp);
      end
   endtask

   task automatic chk_d(exp_t e);
      chk("d_hs", 10'(d_hs), 10'(e.hs));
      chk("d_vs", 10'(d_vs), 10'(e.vs));
      chk("d_de", 10'(d_de), 10'(e.de));
      chk("d_px", d_px, e.px);
      chk("d_py", d_py, e.py);
      chk("d_fs", 10'(d_fs), 10'(e.fs));
      chk("d_ls", 10'(d_ls), 10'(e.ls));
   endtask

   task automatic chk_s(exp_t e);
      chk("s_hs", 10'(s_hs), 10'(e.hs));
      chk("s_vs", 10'(s_vs), 10'(e.vs));
      chk("s_de", 10'(s_de), 10'(e.de));
      chk("s_px", s_px, e.px);
      chk("s_py", s_py, e.py);
      chk("s_fs", 10'(s_fs), 10'(e.fs));
      chk("s_ls", 10'(s_ls), 10'(e.ls));
   endtask

   task automatic step(int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            s1 = 0; s2 = 0; t_d = 0; t_s = 0;
            e_d = idle(1'b0, 1'b0);
            e_s = idle(1'b1, 1'b1);
         end else begin
            if (s2) begin
               e_d = dec(t_d, 480, 2, 41, 2, 272, 2, 10, 2, 0, 0, e_d);
               e_s = dec(t_s, 16, 2, 5, 3, 10, 2, 3, 2, 1, 1, e_s);
               t_d++; t_s++;
            end else begin
               e_d = idle(1'b0, 1'b0);
               e_s = idle(1'b1, 1'b1);
               t_d = 0; t_s = 0;
            end
            s2 = s1;
            s1 = pll_lock;
         end
         @(negedge clk);
         chk_d(e_d);
         chk_s(e_s);
      end
   endtask

   task automatic wait_s_fs(output int at);
      int n;
      n = 0;
      at = -1;
      while (n < 2000 && at < 0) begin
         step(1);
         n++;
         if (s_fs === 1'b1) at = cyc;
      end
      chk("s_fs_timeout", 10'(at < 0), 10'd0);
   endtask

   task automatic wait_d_ls(output int at);
      int n;
      n = 0;
      at = -1;
      while (n < 2000 && at < 0) begin
         step(1);
         n++;
         if (d_ls === 1'b1) at = cyc;
      end
      chk("d_ls_timeout", 10'(at < 0), 10'd0);
   endtask

   initial begin
      int a, b, n;
      e_d = idle(1'b0, 1'b0);
      e_s = idle(1'b1, 1'b1);

      // Idle throughout reset and before lock.
      step(4);
      @(negedge clk);
      rst = 1'b0;
      step(6);

      // Startup: several default lines, which also exercises HSYNC timing.
      pll_lock = 1'b1;
      step(3 * 525 + 40);

      // Line-start period on the default geometry.
      wait_d_ls(a);
      wait_d_ls(b);
      chk("d_line_period", 10'(b - a), 10'd525);

      // Frame-start period on the small geometry (26 x 17 = 442).
      wait_s_fs(a);
      wait_s_fs(b);
      chk("s_frame_period", 10'(b - a), 10'd442);

      // Drop lock mid-line at pix_x=200, then relock.
      n = 0;
      while (n < 2000 && !(e_d.de && e_d.px == 10'd200)) begin
         step(1);
         n++;
      end
      chk("d_px200_timeout", 10'(n >= 2000), 10'd0);
      pll_lock = 1'b0;
      step(8);
      pll_lock = 1'b1;
      step(1000);

      // Random lock glitches and long runs.
      repeat (16) begin
         pll_lock = ($urandom_range(0, 3) != 0);
         step($urandom_range(1, 700));
      end
      pll_lock = 1'b1;
      step(900);

      // Asynchronous reset between edges: outputs must change immediately.
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk_d(idle(1'b0, 1'b0));
      chk_s(idle(1'b1, 1'b1));
      step(3);
      @(negedge clk);
      rst = 1'b0;
      step(1200);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
